tl_ram_slave: RTL and testbench



---
 rtl/tl_ram_slave.sv | 212 +++++++++++++++++++++
 tb/tb_tl_ram_slave.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_ram_slave.sv
// TileLink-UL RAM target: 64-bit flip-flop memory behind one A/D channel pair.
// Handles Get/PutFull/PutPartial bursts and denies out-of-range, oversize or unknown requests.
module tl_ram_slave #(
    parameter int          DEPTH    = 512,
    parameter logic [27:0] BASE     = 28'h0000000,
    parameter int          MAX_SIZE = 6
) (
    input  logic        clock,
    input  logic        reset,
    output logic        auto_in_a_ready,
    input  logic        auto_in_a_valid,
    input  logic [2:0]  auto_in_a_bits_opcode,
    input  logic [3:0]  auto_in_a_bits_size,
    input  logic [4:0]  auto_in_a_bits_source,
    input  logic [27:0] auto_in_a_bits_address,
    input  logic [7:0]  auto_in_a_bits_mask,
    input  logic [63:0] auto_in_a_bits_data,
    input  logic        auto_in_d_ready,
    output logic        auto_in_d_valid,
    output logic [2:0]  auto_in_d_bits_opcode,
    output logic [1:0]  auto_in_d_bits_param,
    output logic [3:0]  auto_in_d_bits_size,
    output logic [4:0]  auto_in_d_bits_source,
    output logic        auto_in_d_bits_sink,
    output logic        auto_in_d_bits_denied,
    output logic [63:0] auto_in_d_bits_data,
    output logic        auto_in_d_bits_corrupt
);

    localparam int          AW     = $clog2(DEPTH);
    localparam logic [28:0] LIMIT  = {1'b0, BASE} + (29'(DEPTH) << 3);
    localparam logic [3:0]  MAX_SZ = 4'(MAX_SIZE);

    typedef enum logic [1:0] {S_IDLE, S_PUT, S_PACK, S_GET} state_t;

    function automatic logic [11:0] last_beat(input logic [3:0] size);
        logic [12:0] n;
        n = (size <= 4'd3) ? 13'd1 : (13'd1 << (size - 4'd3));
        return 12'(n - 13'd1);
    endfunction

    function automatic logic [27:0] burst_base(input logic [27:0] addr, input logic [3:0] size);
        logic [3:0] sh;
        sh = (size < 4'd3) ? 4'd3 : size;
        return addr & ~((28'd1 << sh) - 28'd1);
    endfunction

    logic [63:0]   mem [DEPTH];

    state_t        state;
    logic [11:0]   cnt;
    logic [11:0]   last_q;
    logic [AW-1:0] base_q;
    logic [3:0]    size_q;
    logic [4:0]    source_q;
    logic          denied_q;
    logic          a_ready_q;
    logic          d_valid_q;
    logic [2:0]    d_opcode_q;
    logic [63:0]   d_data_q;
    logic          d_corrupt_q;

    logic          a_fire;
    logic          d_fire;
    logic          in_put;
    logic          in_bad_op;
    logic          in_denied;
    logic [AW-1:0] in_idx;
    logic          wr_en;
    logic [AW-1:0] wr_idx;

    assign a_fire    = a_ready_q & auto_in_a_valid;
    assign d_fire    = d_valid_q & auto_in_d_ready;
    assign in_put    = (auto_in_a_bits_opcode == 3'd0) || (auto_in_a_bits_opcode == 3'd1);
    assign in_bad_op = !in_put && (auto_in_a_bits_opcode != 3'd4);
    // Range check looks only at the request address; later beats wrap modulo DEPTH.
    assign in_denied = (auto_in_a_bits_address < BASE)
                    || ({1'b0, auto_in_a_bits_address} >= LIMIT)
                    || (auto_in_a_bits_size > MAX_SZ)
                    || in_bad_op;
    assign in_idx    = AW'((burst_base(auto_in_a_bits_address, auto_in_a_bits_size) - BASE) >> 3);

    always_comb begin
        wr_en  = 1'b0;
        wr_idx = in_idx;
        if (a_fire) begin
            case (state)
                S_IDLE: begin
                    wr_en  = in_put && !in_denied;
                    wr_idx = in_idx;
                end
                S_PUT: begin
                    wr_en  = !denied_q;
                    wr_idx = base_q + AW'(cnt);
                end
                default: wr_en = 1'b0;
            endcase
        end
    end

    // Memory is deliberately not reset so contents survive a reset pulse.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int i = 0; i < 8; i++) begin
                if (auto_in_a_bits_mask[i])
                    mem[wr_idx][8*i +: 8] <= auto_in_a_bits_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            last_q      <= '0;
            base_q      <= '0;
            size_q      <= '0;
            source_q    <= '0;
            denied_q    <= 1'b0;
            a_ready_q   <= 1'b0;
            d_valid_q   <= 1'b0;
            d_opcode_q  <= '0;
            d_data_q    <= '0;
            d_corrupt_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    a_ready_q <= 1'b1;
                    if (a_fire) begin
                        size_q   <= auto_in_a_bits_size;
                        source_q <= auto_in_a_bits_source;
                        denied_q <= in_denied;
                        base_q   <= in_idx;
                        last_q   <= last_beat(auto_in_a_bits_size);
                        if (in_put) begin
                            if (last_beat(auto_in_a_bits_size) == 12'd0) begin
                                state       <= S_PACK;
                                a_ready_q   <= 1'b0;
                                d_valid_q   <= 1'b1;
                                d_opcode_q  <= 3'd0;
                                d_data_q    <= '0;
                                d_corrupt_q <= 1'b0;
                            end else begin
                                state <= S_PUT;
                                cnt   <= 12'd1;
                            end
                        end else begin
                            // Unknown opcodes fall through here and are answered as denied Gets.
                            state       <= S_GET;
                            cnt         <= 12'd0;
                            a_ready_q   <= 1'b0;
                            d_valid_q   <= 1'b1;
                            d_opcode_q  <= 3'd1;
                            d_data_q    <= in_denied ? 64'd0 : mem[in_idx];
                            d_corrupt_q <= in_denied;
                        end
                    end
                end
                S_PUT: begin
                    if (a_fire) begin
                        if (cnt == last_q) begin
                            state       <= S_PACK;
                            a_ready_q   <= 1'b0;
                            d_valid_q   <= 1'b1;
                            d_opcode_q  <= 3'd0;
                            d_data_q    <= '0;
                            d_corrupt_q <= 1'b0;
                        end else begin
                            cnt <= cnt + 12'd1;
                        end
                    end
                end
                S_PACK: begin
                    if (d_fire) begin
                        state     <= S_IDLE;
                        d_valid_q <= 1'b0;
                        a_ready_q <= 1'b1;
                    end
                end
                S_GET: begin
                    if (d_fire) begin
                        if (cnt == last_q) begin
                            state       <= S_IDLE;
                            cnt         <= 12'd0;
                            d_valid_q   <= 1'b0;
                            a_ready_q   <= 1'b1;
                            d_data_q    <= '0;
                            d_corrupt_q <= 1'b0;
                        end else begin
                            // Prefetch the next beat so D data only changes on a handshake.
                            cnt      <= cnt + 12'd1;
                            d_data_q <= denied_q ? 64'd0 : mem[base_q + AW'(cnt + 12'd1)];
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign auto_in_a_ready        = a_ready_q;
    assign auto_in_d_valid        = d_valid_q;
    assign auto_in_d_bits_opcode  = d_opcode_q;
    assign auto_in_d_bits_param   = 2'd0;
    assign auto_in_d_bits_size    = size_q;
    assign auto_in_d_bits_source  = source_q;
    assign auto_in_d_bits_sink    = 1'b0;
    assign auto_in_d_bits_denied  = denied_q;
    assign auto_in_d_bits_data    = d_data_q;
    assign auto_in_d_bits_corrupt = d_corrupt_q;

endmodule

// File: tb/tb_tl_ram_slave.sv
// Bench for tl_ram_slave: directed scenarios plus randomized traffic checked
// against an array-based memory model computed from the TileLink rules.
module tb_tl_ram_slave;

    localparam int          DEPTH    = 512;
    localparam logic [27:0] BASE     = 28'h0000000;
    localparam int          MAX_SIZE = 6;
    localparam logic [27:0] TOP      = BASE + 28'(DEPTH * 8);

    logic        clock = 1'b0;
    logic        reset;
    logic        a_ready, a_valid;
    logic [2:0]  a_opcode;
    logic [3:0]  a_size;
    logic [4:0]  a_source;
    logic [27:0] a_address;
    logic [7:0]  a_mask;
    logic [63:0] a_data;
    logic        d_ready, d_valid;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [3:0]  d_size;
    logic [4:0]  d_source;
    logic        d_sink, d_denied, d_corrupt;
    logic [63:0] d_data;
    logic [81:0] d_bus;

    int checks = 0;
    int errors = 0;
    logic [63:0] ref_mem [DEPTH];

    assign d_bus = {d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_corrupt, d_data};

    tl_ram_slave #(.DEPTH(DEPTH), .BASE(BASE), .MAX_SIZE(MAX_SIZE)) dut (
        .clock                  (clock),
        .reset                  (reset),
        .auto_in_a_ready        (a_ready),
        .auto_in_a_valid        (a_valid),
        .auto_in_a_bits_opcode  (a_opcode),
        .auto_in_a_bits_size    (a_size),
        .auto_in_a_bits_source  (a_source),
        .auto_in_a_bits_address (a_address),
        .auto_in_a_bits_mask    (a_mask),
        .auto_in_a_bits_data    (a_data),
        .auto_in_d_ready        (d_ready),
        .auto_in_d_valid        (d_valid),
        .auto_in_d_bits_opcode  (d_opcode),
        .auto_in_d_bits_param   (d_param),
        .auto_in_d_bits_size    (d_size),
        .auto_in_d_bits_source  (d_source),
        .auto_in_d_bits_sink    (d_sink),
        .auto_in_d_bits_denied  (d_denied),
        .auto_in_d_bits_data    (d_data),
        .auto_in_d_bits_corrupt (d_corrupt)
    );

    always #5 clock = ~clock;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int n_beats(input logic [3:0] size);
        return (size <= 4'd3) ? 1 : (1 << (int'(size) - 3));
    endfunction

    function automatic bit exp_denied(input logic [2:0] op, input logic [3:0] size, input logic [27:0] addr);
        longint a;
        a = longint'(addr);
        return (a < longint'(BASE)) || (a >= longint'(BASE) + DEPTH * 8) ||
               (int'(size) > MAX_SIZE) || !(op == 3'd0 || op == 3'd1 || op == 3'd4);
    endfunction

    function automatic int word_of(input logic [3:0] size, input logic [27:0] addr, input int k);
        longint al;
        int lg;
        lg = (size < 4'd3) ? 3 : int'(size);
        al = (longint'(addr) >> lg) << lg;
        return int'(((al - longint'(BASE)) / 8 + k) % DEPTH);
    endfunction

    // ---------------- stimulus tasks ----------------
    task automatic send_a(input logic [2:0] op, input logic [3:0] size, input logic [4:0] src,
                          input logic [27:0] addr, input logic [7:0] mask, input logic [63:0] data);
        bit fired;
        fired = 0;
        a_valid = 1'b1; a_opcode = op; a_size = size; a_source = src;
        a_address = addr; a_mask = mask; a_data = data;
        for (int c = 0; c < 50; c++) begin
            if (a_ready === 1'b1) begin
                @(negedge clock);
                fired = 1;
                break;
            end
            @(negedge clock);
        end
        checks++;
        if (!fired) begin
            errors++;
            $display("FAIL a_accept: got a_ready=%b expected 1 within 50 cycles", a_ready);
        end
    endtask

    task automatic do_put(input logic [2:0] op, input logic [3:0] size, input logic [4:0] src,
                          input logic [27:0] addr, input logic [7:0] mask, input bit rnd,
                          input logic [63:0] d0, input int ack_wait);
        int n, w;
        bit den;
        logic [63:0] bd;
        logic [81:0] exp;
        n = n_beats(size);
        den = exp_denied(op, size, addr);
        for (int k = 0; k < n; k++) begin
            bd = rnd ? {$urandom, $urandom} : d0 + 64'(k);
            send_a(op, size, src, addr, mask, bd);
            if (!den) begin
                w = word_of(size, addr, k);
                for (int b = 0; b < 8; b++)
                    if (mask[b]) ref_mem[w][8*b +: 8] = bd[8*b +: 8];
            end
            if (k < n - 1) begin
                checks++;
                if (d_valid !== 1'b0 || a_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL put_beat%0d: got d_valid=%b a_ready=%b expected 0/1", k, d_valid, a_ready);
                end
            end
        end
        a_valid = 1'b0;
        exp = {1'b1, 3'd0, 2'd0, size, src, 1'b0, den, 1'b0, 64'd0};
        for (int s = 0; s <= ack_wait; s++) begin
            d_ready = (s == ack_wait);
            checks++;
            if (d_bus !== exp || a_ready !== 1'b0) begin
                errors++;
                $display("FAIL put_ack: got %h a_ready=%b expected %h a_ready=0", d_bus, a_ready, exp);
            end
            @(negedge clock);
        end
        d_ready = 1'b0;
        checks++;
        if (d_valid !== 1'b0 || a_ready !== 1'b1) begin
            errors++;
            $display("FAIL put_done: got d_valid=%b a_ready=%b expected 0/1", d_valid, a_ready);
        end
    endtask

    task automatic do_get(input logic [2:0] op, input logic [3:0] size, input logic [4:0] src,
                          input logic [27:0] addr, input int mode);
        int n, k, cyc, w;
        bit den, rdy;
        logic [81:0] exp;
        n = n_beats(size);
        den = exp_denied(op, size, addr);
        send_a(op, size, src, addr, 8'hFF, 64'd0);
        a_valid = 1'b0;
        k = 0; cyc = 0;
        while (k < n && cyc < 4000) begin
            case (mode)
                0: rdy = 1'b1;
                1: rdy = cyc[0];
                default: rdy = ($urandom % 3) != 0;
            endcase
            d_ready = rdy;
            w = word_of(size, addr, k);
            exp = {1'b1, 3'd1, 2'd0, size, src, 1'b0, den, den, den ? 64'd0 : ref_mem[w]};
            checks++;
            if (d_bus !== exp || a_ready !== 1'b0) begin
                errors++;
                $display("FAIL get_beat%0d: got %h a_ready=%b expected %h a_ready=0", k, d_bus, a_ready, exp);
            end
            @(negedge clock);
            if (rdy) k++;
            cyc++;
        end
        d_ready = 1'b0;
        checks++;
        if (k != n) begin
            errors++;
            $display("FAIL get_timeout: got %0d beats expected %0d", k, n);
        end
        checks++;
        if (d_valid !== 1'b0 || a_ready !== 1'b1) begin
            errors++;
            $display("FAIL get_done: got d_valid=%b a_ready=%b expected 0/1", d_valid, a_ready);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (2) @(negedge clock);
        checks++;
        if ({a_ready, d_bus} !== 83'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {a_ready, d_bus});
        end
        reset = 1'b1;
        #1;
        checks++;
        if (a_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got a_ready=%b expected 0 before first edge", a_ready);
        end
        @(negedge clock);
        checks++;
        if (a_ready !== 1'b1 || d_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got a_ready=%b d_valid=%b expected 1/0", a_ready, d_valid);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH / 8; i++)
            do_put(3'd0, 4'd6, 5'(i), BASE + 28'(i * 64), 8'hFF, 1'b1, 64'd0, 0);
    endtask

    task automatic test_basic();
        logic [81:0] exp;
        do_put(3'd0, 4'd3, 5'd5, BASE + 28'h10, 8'hFF, 1'b0, 64'h1122334455667788, 1);
        send_a(3'd4, 4'd3, 5'd9, BASE + 28'h10, 8'hFF, 64'd0);
        a_valid = 1'b0;
        d_ready = 1'b1;
        exp = {1'b1, 3'd1, 2'd0, 4'd3, 5'd9, 1'b0, 1'b0, 1'b0, 64'h1122334455667788};
        checks++;
        if (d_bus !== exp) begin
            errors++;
            $display("FAIL basic_get: got %h expected %h", d_bus, exp);
        end
        @(negedge clock);
        d_ready = 1'b0;
    endtask

    task automatic test_partial();
        do_put(3'd1, 4'd3, 5'd6, BASE + 28'h10, 8'h0F, 1'b0, 64'hFFFFFFFFAAAAAAAA, 0);
        send_a(3'd4, 4'd3, 5'd7, BASE + 28'h10, 8'hFF, 64'd0);
        a_valid = 1'b0;
        d_ready = 1'b1;
        checks++;
        if (d_valid !== 1'b1 || d_data !== 64'h11223344AAAAAAAA) begin
            errors++;
            $display("FAIL partial_get: got v=%b %h expected v=1 11223344aaaaaaaa", d_valid, d_data);
        end
        @(negedge clock);
        d_ready = 1'b0;
    endtask

    task automatic test_burst();
        do_put(3'd0, 4'd6, 5'd3, BASE + 28'h40, 8'hFF, 1'b0, 64'd0, 2);
        do_get(3'd4, 4'd6, 5'd11, BASE + 28'h40, 1);
    endtask

    task automatic test_denied();
        do_get(3'd4, 4'd3, 5'd1, TOP, 0);
        do_get(3'd4, 4'd7, 5'd2, BASE + 28'h80, 2);
        do_get(3'd5, 4'd3, 5'd4, BASE + 28'h10, 0);
        do_put(3'd0, 4'd3, 5'd8, TOP + 28'h10, 8'hFF, 1'b0, 64'hDEADBEEFCAFEF00D, 0);
        do_put(3'd0, 4'd7, 5'd9, BASE + 28'h100, 8'hFF, 1'b1, 64'd0, 1);
        do_get(3'd4, 4'd3, 5'd10, BASE + 28'h10, 0);
        do_get(3'd4, 4'd6, 5'd12, BASE + 28'h100, 0);
    endtask

    task automatic test_back_to_back();
        logic [81:0] exp;
        send_a(3'd4, 4'd3, 5'd13, BASE + 28'h40, 8'hFF, 64'd0);
        a_opcode = 3'd4; a_size = 4'd3; a_source = 5'd14; a_address = BASE + 28'h48;
        a_valid = 1'b1;
        d_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (a_ready !== 1'b0 || d_valid !== 1'b1) begin
                errors++;
                $display("FAIL b2b_stall%0d: got a_ready=%b d_valid=%b expected 0/1", s, a_ready, d_valid);
            end
            @(negedge clock);
        end
        d_ready = 1'b1;
        @(negedge clock);
        d_ready = 1'b0;
        checks++;
        if (a_ready !== 1'b1 || d_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: got a_ready=%b d_valid=%b expected 1/0", a_ready, d_valid);
        end
        @(negedge clock);
        a_valid = 1'b0;
        exp = {1'b1, 3'd1, 2'd0, 4'd3, 5'd14, 1'b0, 1'b0, 1'b0, ref_mem[word_of(4'd3, BASE + 28'h48, 0)]};
        checks++;
        if (d_bus !== exp) begin
            errors++;
            $display("FAIL b2b_second: got %h expected %h", d_bus, exp);
        end
        d_ready = 1'b1;
        @(negedge clock);
        d_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        send_a(3'd4, 4'd6, 5'd15, BASE + 28'h40, 8'hFF, 64'd0);
        a_valid = 1'b0;
        d_ready = 1'b1;
        repeat (3) @(negedge clock);
        d_ready = 1'b0;
        checks++;
        if (d_valid !== 1'b1 || d_data !== ref_mem[word_of(4'd6, BASE + 28'h40, 3)]) begin
            errors++;
            $display("FAIL mid_beat3: got v=%b %h expected v=1 %h", d_valid, d_data,
                     ref_mem[word_of(4'd6, BASE + 28'h40, 3)]);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({a_ready, d_bus} !== 83'd0) begin
            errors++;
            $display("FAIL mid_async: got %h expected 0", {a_ready, d_bus});
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (a_ready !== 1'b1 || d_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_release: got a_ready=%b d_valid=%b expected 1/0", a_ready, d_valid);
        end
        do_get(3'd4, 4'd6, 5'd16, BASE + 28'h40, 0);
    endtask

    task automatic test_random();
        int r, x;
        logic [3:0]  size;
        logic [4:0]  src;
        logic [27:0] addr;
        for (int it = 0; it < 60; it++) begin
            r    = int'($urandom % 8);
            size = 4'($urandom % 8);
            src  = 5'($urandom);
            if (($urandom % 8) == 0) addr = TOP + 28'($urandom % 4096);
            else                     addr = BASE + 28'($urandom % (DEPTH * 8));
            if (r < 3)      do_put(3'd0, size, src, addr, 8'hFF, 1'b1, 64'd0, int'($urandom % 3));
            else if (r == 3) do_put(3'd1, size, src, addr, 8'($urandom), 1'b1, 64'd0, int'($urandom % 3));
            else if (r < 7) do_get(3'd4, size, src, addr, 2);
            else begin
                x = int'($urandom % 5);
                do_get(3'((x < 2) ? 2 + x : 3 + x), size, src, addr, 2);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        a_valid = 1'b0; a_opcode = '0; a_size = '0; a_source = '0;
        a_address = '0; a_mask = '0; a_data = '0;
        d_ready = 1'b0;
        test_reset();
        test_fill();
        test_basic();
        test_partial();
        test_burst();
        test_denied();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
